// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared MAC walks all taps per sample,
// with a configuration-writable coefficient file and a saturated 16-bit result.
module fir_mac_sequencer #(
   parameter int TAPS       = 4,
   parameter int RESET_COEF = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [7:0]  cfg_data,
   output logic        cfg_err,
   output logic        busy
);

   localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int AW = 16 + IW;
   localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                state, state_next;
   logic signed [7:0]     d [TAPS];
   logic signed [7:0]     c [TAPS];
   logic signed [AW-1:0]  acc, acc_sum;
   logic [IW-1:0]         idx;
   logic signed [15:0]    prod;
   logic [15:0]           y_sat;
   logic                  take, last, cfg_ok;

   assign take   = in_valid && (state == IDLE);
   assign last   = (idx == IW'(TAPS - 1));
   assign cfg_ok = (state == IDLE) && ({28'd0, cfg_addr} < 32'(TAPS));
   assign prod   = d[idx] * c[idx];

   always_comb begin
      acc_sum = acc + {{IW{prod[15]}}, prod};
      if (acc_sum > SAT_MAX)
         y_sat = 16'h7fff;
      else if (acc_sum < SAT_MIN)
         y_sat = 16'h8000;
      else
         y_sat = acc_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid)
               state_next = MAC;
         end
         MAC: begin
            if (last)
               state_next = OUT;
         end
         OUT: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A coefficient write coinciding with a sample handshake lands before MAC reads it.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         idx       <= '0;
         y         <= '0;
         out_valid <= 1'b0;
         cfg_err   <= 1'b0;
         for (int unsigned k = 0; k < TAPS; k++) begin
            d[k] <= '0;
            c[k] <= 8'(RESET_COEF);
         end
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (cfg_we && cfg_ok)
            c[cfg_addr[IW-1:0]] <= cfg_data;
         if (take) begin
            d[0] <= x;
            for (int unsigned k = 1; k < TAPS; k++)
               d[k] <= d[k-1];
            acc <= '0;
            idx <= '0;
         end
         case (state)
            MAC: begin
               acc <= acc_sum;
               idx <= last ? '0 : idx + 1'b1;
               if (last) begin
                  y         <= y_sat;
                  out_valid <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a plain-arithmetic FIR model.
module tb_fir_mac_sequencer;

   localparam int TAPS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  x = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] y;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [7:0]  cfg_data = '0;
   logic        cfg_err;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int md [TAPS];
   int mc [TAPS];

   fir_mac_sequencer #(.TAPS(TAPS), .RESET_COEF(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [15:0] model_y();
      int s = 0;
      for (int k = 0; k < TAPS; k++) s += md[k] * mc[k];
      return 16'(sat16(s));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < TAPS; k++) begin md[k] = 0; mc[k] = 1; end
   endtask

   task automatic model_cfg(input int a, input int dv);
      if (a < TAPS) mc[a] = dv;
   endtask

   task automatic model_push(input int xv);
      for (int k = TAPS - 1; k > 0; k--) md[k] = md[k-1];
      md[0] = xv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      model_reset();
   endtask

   // IDLE-only coefficient write; err returns cfg_err in the following cycle.
   task automatic cfg_write(input int a, input int dv, output logic err);
      cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 8'(dv);
      tick();
      cfg_we = 1'b0;
      err = cfg_err;
      model_cfg(a, dv);
   endtask

   task automatic run_sample(input int xv, input bit we, input int a, input int dv,
                             input int hold, output logic [15:0] yv, output int lat);
      lat = 99; yv = 'x;
      for (int i = 0; i < 50 && !in_ready; i++) tick();
      if (!in_ready) return;
      in_valid = 1'b1; x = 8'(xv);
      if (we) begin cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 8'(dv); end
      tick();
      in_valid = 1'b0; cfg_we = 1'b0;
      if (we) model_cfg(a, dv);
      model_push(xv);
      lat = 0;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      if (!out_valid) begin lat = 99; return; end
      yv = y;
      repeat (hold) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({y, out_valid, cfg_err, busy, in_ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_outputs: y=%h ov=%b err=%b busy=%b ir=%b, want 0 0 0 0 1",
                  y, out_valid, cfg_err, busy, in_ready);
      end
   endtask

   task automatic test_basic();
      int exp_tab [5] = '{1, 3, 6, 10, 14};
      logic [15:0] yv; int lat;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_sample(i + 1, 1'b0, 0, 0, 0, yv, lat);
         checks++;
         if (yv !== 16'(exp_tab[i])) begin
            errors++; $display("FAIL basic_y[%0d]: got %0d want %0d", i, $signed(yv), exp_tab[i]);
         end
         checks++;
         if (lat !== TAPS) begin
            errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, TAPS);
         end
      end
   endtask

   task automatic test_saturation();
      int pos_tab [3] = '{16129, 32258, 32767};
      int neg_tab [3] = '{-16256, -32512, -32768};
      logic [15:0] yv; int lat; logic err;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int k = 0; k < TAPS; k++) begin
            cfg_write(k, 127, err);
            checks++;
            if (err !== 1'b0) begin
               errors++; $display("FAIL sat_cfg_err[%0d]: got %b want 0", k, err);
            end
         end
         for (int i = 0; i < 3; i++) begin
            run_sample(pass == 0 ? 127 : -128, 1'b0, 0, 0, 0, yv, lat);
            checks++;
            if (yv !== 16'(pass == 0 ? pos_tab[i] : neg_tab[i])) begin
               errors++;
               $display("FAIL sat_y[%0d][%0d]: got %0d want %0d", pass, i, $signed(yv),
                        pass == 0 ? pos_tab[i] : neg_tab[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] exp; int n = 0;
      do_reset();
      in_valid = 1'b1; x = 8'd50;
      tick();
      in_valid = 1'b0;
      model_push(50);
      exp = model_y();
      while (!out_valid && n < 50) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, y, in_ready, busy} !== {1'b1, exp, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: ov=%b y=%0d ir=%b busy=%b, want 1 %0d 0 1",
                     i, out_valid, $signed(y), in_ready, busy, $signed(exp));
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL backpressure_release: ov=%b ir=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_cfg_errors();
      logic [15:0] yv; int lat; int n = 0; logic err;
      do_reset();
      in_valid = 1'b1; x = 8'd10;
      tick();
      in_valid = 1'b0;
      model_push(10);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd5;
      tick();
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_mac_pulse: got %b want 1", cfg_err); end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_mac_clear: got %b want 0", cfg_err); end
      while (!out_valid && n < 50) begin tick(); n++; end
      checks++;
      if (y !== model_y()) begin
         errors++; $display("FAIL cfg_mac_unchanged_y: got %0d want %0d", $signed(y), $signed(model_y()));
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      cfg_write(9, 77, err);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL cfg_err_addr9_pulse: got %b want 1", err); end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_addr9_clear: got %b want 0", cfg_err); end
      run_sample(1, 1'b0, 0, 0, 0, yv, lat);
      checks++;
      if (yv !== 16'd11) begin errors++; $display("FAIL cfg_addr9_unchanged_y: got %0d want 11", $signed(yv)); end
      do_reset();
      cfg_write(0, 2, err);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL cfg_ok_no_err: got %b want 0", err); end
      run_sample(3, 1'b0, 0, 0, 0, yv, lat);
      checks++;
      if (yv !== 16'd6) begin errors++; $display("FAIL cfg_write_y: got %0d want 6", $signed(yv)); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] yv; int lat;
      do_reset();
      run_sample(9, 1'b0, 0, 0, 0, yv, lat);
      in_valid = 1'b1; x = 8'd9;
      tick();
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      checks++;
      if ({out_valid, y, in_ready, busy} !== {1'b0, 16'h0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_outputs: ov=%b y=%0d ir=%b busy=%b, want 0 0 1 0",
                  out_valid, $signed(y), in_ready, busy);
      end
      run_sample(7, 1'b0, 0, 0, 0, yv, lat);
      checks++;
      if (yv !== 16'd7) begin errors++; $display("FAIL reset_mid_line_cleared: got %0d want 7", $signed(yv)); end
   endtask

   task automatic test_same_cycle_write();
      logic [15:0] yv; int lat;
      do_reset();
      run_sample(4, 1'b1, 0, 3, 0, yv, lat);
      checks++;
      if (yv !== 16'd12) begin errors++; $display("FAIL same_cycle_write_y: got %0d want 12", $signed(yv)); end
   endtask

   task automatic test_random();
      logic [15:0] yv, exp; int lat; logic err; int a, dv;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(0, 7);
            dv = $signed(8'($urandom));
            cfg_write(a, dv, err);
            checks++;
            if (err !== (a >= TAPS)) begin
               errors++; $display("FAIL rand_cfg_err[%0d]: got %b want %b (addr %0d)", i, err, a >= TAPS, a);
            end
         end
         a = $urandom_range(0, 5);
         dv = $signed(8'($urandom));
         run_sample($signed(8'($urandom)), $urandom_range(0, 3) == 0, a, dv,
                    $urandom_range(0, 3), yv, lat);
         exp = model_y();
         checks++;
         if (yv !== exp || lat !== TAPS) begin
            errors++;
            $display("FAIL rand_sample[%0d]: y=%0d lat=%0d, want y=%0d lat=%0d",
                     i, $signed(yv), lat, $signed(exp), TAPS);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_cfg_errors();
      test_reset_mid();
      test_same_cycle_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
